// File: rtl/commit_sequencer.sv
// rtl/commit_sequencer.sv - GL head retirement sequencer: store/CSR serialisation, traps, instret
module commit_sequencer #(
   parameter int GL_IDX_W = 5,
   parameter int CNT_W    = 64
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic [1:0]          head_valid_i,
   input  logic [1:0]          head_is_store_i,
   input  logic [1:0]          head_is_csr_i,
   input  logic [1:0]          head_ex_valid_i,
   input  logic [GL_IDX_W-1:0] head_gl_index_i,
   input  logic                halt_i,
   output logic                store_commit_valid_o,
   input  logic                store_commit_ready_i,
   output logic                csr_req_o,
   input  logic                csr_done_i,
   input  logic                csr_ex_i,
   output logic [1:0]          read_head_o,
   output logic                flush_commit_o,
   output logic                trap_valid_o,
   output logic [GL_IDX_W-1:0] trap_gl_index_o,
   output logic [CNT_W-1:0]    instret_o
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ST_WAIT  = 3'd1,
      S_CSR_REQ  = 3'd2,
      S_CSR_WAIT = 3'd3,
      S_TRAP     = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [GL_IDX_W-1:0] r_trap_idx;
   logic [CNT_W-1:0]    r_instret;

   logic [1:0]          w_read_head;
   logic [1:0]          w_pop_cnt;
   logic                w_latch_trap;
   logic                w_store_valid;
   logic                w_csr_req;
   logic                w_trap;
   logic                w_slot1_plain;

   // Slot 1 may only ride along with a plain slot 0 when it is itself plain and finished.
   assign w_slot1_plain = head_valid_i[1] & ~(head_is_store_i[1] | head_is_csr_i[1] | head_ex_valid_i[1]);

   // Commit decision: next state, pops and handshake strobes; the head is frozen while waiting.
   always_comb begin
      w_state_nxt   = r_state;
      w_read_head   = 2'b00;
      w_latch_trap  = 1'b0;
      w_store_valid = 1'b0;
      w_csr_req     = 1'b0;
      w_trap        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!halt_i && head_valid_i[0]) begin
               if (head_ex_valid_i[0]) begin
                  w_latch_trap = 1'b1;
                  w_state_nxt  = S_TRAP;
               end else if (head_is_store_i[0]) begin
                  w_state_nxt = S_ST_WAIT;
               end else if (head_is_csr_i[0]) begin
                  w_state_nxt = S_CSR_REQ;
               end else begin
                  w_read_head = {w_slot1_plain, 1'b1};
               end
            end
         end
         S_ST_WAIT: begin
            w_store_valid = 1'b1;
            if (store_commit_ready_i) begin
               w_read_head = 2'b01;
               w_state_nxt = S_IDLE;
            end
         end
         S_CSR_REQ: begin
            w_csr_req   = 1'b1;
            w_state_nxt = S_CSR_WAIT;
         end
         S_CSR_WAIT: begin
            if (csr_done_i) begin
               if (csr_ex_i) begin
                  w_latch_trap = 1'b1;
                  w_state_nxt  = S_TRAP;
               end else begin
                  w_read_head = 2'b01;
                  w_state_nxt = S_IDLE;
               end
            end
         end
         S_TRAP: begin
            w_trap      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign w_pop_cnt = {1'b0, w_read_head[0]} + {1'b0, w_read_head[1]};

   // State register; async reset drops any in-flight store or CSR wait.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Capture the GL index of the faulting head for the trap cycle.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_trap_idx <= '0;
      end else if (w_latch_trap) begin
         r_trap_idx <= head_gl_index_i;
      end
   end

   // Retired-instruction counter: counts pops only, so trapping instructions never count.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_instret <= '0;
      end else begin
         r_instret <= r_instret + CNT_W'(w_pop_cnt);
      end
   end

   // Pops are combinational from the head, so mask them while reset is held.
   assign read_head_o          = rstn_i ? w_read_head : 2'b00;
   assign store_commit_valid_o = w_store_valid;
   assign csr_req_o            = w_csr_req;
   assign flush_commit_o       = w_trap;
   assign trap_valid_o         = w_trap;
   assign trap_gl_index_o      = r_trap_idx;
   assign instret_o            = r_instret;

endmodule

// File: tb/tb_commit_sequencer.sv
// tb/tb_commit_sequencer.sv - self-checking bench for commit_sequencer
module tb_commit_sequencer;
   localparam int GW = 5;
   localparam int CW = 64;

   typedef struct packed {
      logic       st;
      logic       cs;
      logic       ex;
      logic [4:0] idx;
   } ent_t;

   logic          clk = 1'b0;
   logic          rstn;
   logic [1:0]    hv, hs, hc, he;
   logic [GW-1:0] hidx;
   logic          halt, st_ready, csr_done, csr_ex;
   logic          st_valid, csr_req, flush, trap;
   logic [1:0]    rh;
   logic [GW-1:0] trap_idx;
   logic [CW-1:0] instret;
   logic          s_sv, s_cr, s_fl, s_tv;
   logic [1:0]    s_rh;
   logic [GW-1:0] s_tidx;
   logic [2:0]    s_instret;

   logic [CW-1:0] m_instret;
   int            nvec = 0;
   int            nerr = 0;
   wire  [5:0]    obs = {rh, st_valid, csr_req, flush, trap};

   always #5 clk = ~clk;

   commit_sequencer #(.GL_IDX_W(GW), .CNT_W(CW)) dut (
      .clk_i(clk), .rstn_i(rstn), .head_valid_i(hv), .head_is_store_i(hs),
      .head_is_csr_i(hc), .head_ex_valid_i(he), .head_gl_index_i(hidx), .halt_i(halt),
      .store_commit_valid_o(st_valid), .store_commit_ready_i(st_ready), .csr_req_o(csr_req),
      .csr_done_i(csr_done), .csr_ex_i(csr_ex), .read_head_o(rh), .flush_commit_o(flush),
      .trap_valid_o(trap), .trap_gl_index_o(trap_idx), .instret_o(instret)
   );

   commit_sequencer #(.GL_IDX_W(GW), .CNT_W(3)) dut_small (
      .clk_i(clk), .rstn_i(rstn), .head_valid_i(hv), .head_is_store_i(hs),
      .head_is_csr_i(hc), .head_ex_valid_i(he), .head_gl_index_i(hidx), .halt_i(halt),
      .store_commit_valid_o(s_sv), .store_commit_ready_i(st_ready), .csr_req_o(s_cr),
      .csr_done_i(csr_done), .csr_ex_i(csr_ex), .read_head_o(s_rh), .flush_commit_o(s_fl),
      .trap_valid_o(s_tv), .trap_gl_index_o(s_tidx), .instret_o(s_instret)
   );

   function automatic logic [5:0] ev(input logic [1:0] r, input logic s, input logic c,
                                     input logic f, input logic t);
      return {r, s, c, f, t};
   endfunction

   task automatic adv;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      hv = 2'b00; hs = 2'b00; hc = 2'b00; he = 2'b00; hidx = '0;
      halt = 1'b0; st_ready = 1'b0; csr_done = 1'b0; csr_ex = 1'b0;
   endtask

   task automatic test_reset;
      logic [5:0] e;
      idle_inputs();
      rstn = 1'b0;
      m_instret = '0;
      hv = 2'b11;
      @(negedge clk);
      e = ev(2'b00, 0, 0, 0, 0);
      nvec++;
      if (obs !== e || instret !== m_instret || trap_idx !== 5'd0) begin
         nerr++;
         $display("FAIL reset: out=%b exp=%b instret=%0d exp=%0d tidx=%0d exp=0", obs, e, instret, m_instret, trap_idx);
      end
      adv();
      rstn = 1'b1;
      hv = 2'b00;
   endtask

   task automatic test_wrap;
      logic [5:0] e;
      hv = 2'b01;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         e = ev(2'b01, 0, 0, 0, 0);
         nvec++;
         if (obs !== e || instret !== m_instret) begin
            nerr++;
            $display("FAIL wrap_single: out=%b exp=%b instret=%0d exp=%0d", obs, e, instret, m_instret);
         end
         adv();
         m_instret = m_instret + 1;
      end
      hv = 2'b11;
      adv();
      m_instret = m_instret + 2;
      hv = 2'b00;
      @(negedge clk);
      nvec++;
      if (s_instret !== 3'd1 || instret !== m_instret) begin
         nerr++;
         $display("FAIL wrap: small=%0d exp=1 instret=%0d exp=%0d", s_instret, instret, m_instret);
      end
      adv();
   endtask

   task automatic test_dual_plain;
      logic [5:0] e;
      logic [CW-1:0] base;
      base = m_instret;
      hv = 2'b11;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         e = ev(2'b11, 0, 0, 0, 0);
         nvec++;
         if (obs !== e || instret !== m_instret) begin
            nerr++;
            $display("FAIL dual_plain: out=%b exp=%b instret=%0d exp=%0d", obs, e, instret, m_instret);
         end
         adv();
         m_instret = m_instret + 2;
      end
      hv = 2'b00;
      @(negedge clk);
      nvec++;
      if (instret !== base + 64'd6) begin
         nerr++;
         $display("FAIL dual_plain_total: instret=%0d exp=%0d", instret, base + 64'd6);
      end
      adv();
   endtask

   task automatic test_store_wait;
      logic [5:0] e;
      hv = 2'b01; hs = 2'b01;
      for (int c = 0; c <= 5; c++) begin
         st_ready = (c == 5);
         halt = (c == 3);
         @(negedge clk);
         if (c == 0) e = ev(2'b00, 0, 0, 0, 0);
         else if (c < 5) e = ev(2'b00, 1, 0, 0, 0);
         else e = ev(2'b01, 1, 0, 0, 0);
         nvec++;
         if (obs !== e || instret !== m_instret) begin
            nerr++;
            $display("FAIL store_wait c%0d: out=%b exp=%b instret=%0d exp=%0d", c, obs, e, instret, m_instret);
         end
         adv();
      end
      m_instret = m_instret + 1;
      idle_inputs();
      @(negedge clk);
      e = ev(2'b00, 0, 0, 0, 0);
      nvec++;
      if (obs !== e || instret !== m_instret) begin
         nerr++;
         $display("FAIL store_done: out=%b exp=%b instret=%0d exp=%0d", obs, e, instret, m_instret);
      end
      adv();
   endtask

   task automatic test_plain_then_store;
      logic [5:0] e;
      hv = 2'b11; hs = 2'b10;
      @(negedge clk);
      e = ev(2'b01, 0, 0, 0, 0);
      nvec++;
      if (obs !== e) begin
         nerr++;
         $display("FAIL plain_then_store pop: out=%b exp=%b", obs, e);
      end
      adv();
      m_instret = m_instret + 1;
      hv = 2'b01; hs = 2'b01;
      @(negedge clk);
      e = ev(2'b00, 0, 0, 0, 0);
      nvec++;
      if (obs !== e || instret !== m_instret) begin
         nerr++;
         $display("FAIL plain_then_store obs: out=%b exp=%b instret=%0d exp=%0d", obs, e, instret, m_instret);
      end
      adv();
      st_ready = 1'b1;
      @(negedge clk);
      e = ev(2'b01, 1, 0, 0, 0);
      nvec++;
      if (obs !== e) begin
         nerr++;
         $display("FAIL plain_then_store hs: out=%b exp=%b", obs, e);
      end
      adv();
      m_instret = m_instret + 1;
      idle_inputs();
   endtask

   task automatic test_csr_trap;
      logic [5:0] e;
      hv = 2'b01; hc = 2'b01; hidx = 5'd7;
      for (int c = 0; c <= 5; c++) begin
         csr_done = (c == 4);
         csr_ex = (c == 4);
         @(negedge clk);
         if (c == 1) e = ev(2'b00, 0, 1, 0, 0);
         else if (c == 5) e = ev(2'b00, 0, 0, 1, 1);
         else e = ev(2'b00, 0, 0, 0, 0);
         nvec++;
         if (obs !== e || instret !== m_instret || (c == 5 && trap_idx !== 5'd7)) begin
            nerr++;
            $display("FAIL csr_trap c%0d: out=%b exp=%b instret=%0d exp=%0d tidx=%0d", c, obs, e, instret, m_instret, trap_idx);
         end
         adv();
         if (c == 4) begin
            idle_inputs();
            hidx = 5'd12;
         end
      end
   endtask

   task automatic test_exception;
      logic [5:0] e;
      hv = 2'b11; he = 2'b01; hs = 2'b01; hc = 2'b01; hidx = 5'd31;
      @(negedge clk);
      e = ev(2'b00, 0, 0, 0, 0);
      nvec++;
      if (obs !== e) begin
         nerr++;
         $display("FAIL exc_obs: out=%b exp=%b", obs, e);
      end
      adv();
      hidx = 5'd3;
      @(negedge clk);
      e = ev(2'b00, 0, 0, 1, 1);
      nvec++;
      if (obs !== e || trap_idx !== 5'd31 || instret !== m_instret) begin
         nerr++;
         $display("FAIL exc_trap: out=%b exp=%b tidx=%0d exp=31 instret=%0d exp=%0d", obs, e, trap_idx, instret, m_instret);
      end
      adv();
      idle_inputs();
   endtask

   task automatic test_halt_ignore;
      logic [5:0] e;
      hv = 2'b11; halt = 1'b1;
      @(negedge clk);
      e = ev(2'b00, 0, 0, 0, 0);
      nvec++;
      if (obs !== e) begin
         nerr++;
         $display("FAIL halt: out=%b exp=%b", obs, e);
      end
      adv();
      hv = 2'b10; halt = 1'b0;
      @(negedge clk);
      nvec++;
      if (obs !== e || instret !== m_instret) begin
         nerr++;
         $display("FAIL slot1_only: out=%b exp=%b instret=%0d exp=%0d", obs, e, instret, m_instret);
      end
      adv();
      idle_inputs();
   endtask

   task automatic test_random;
      ent_t gl[$];
      ent_t x;
      int gen = 0;
      int d;
      bit tr;
      logic [5:0] e;
      logic [1:0] pops;
      for (int it = 0; it < 600; it++) begin
         while (gl.size() < 4 && gen < 150) begin
            x = '0;
            x.idx = 5'(gen);
            case ($urandom_range(0, 9))
               0, 1: x.st = 1'b1;
               2, 3: x.cs = 1'b1;
               4: begin x.ex = 1'b1; x.st = 1'($urandom_range(0, 1)); x.cs = 1'($urandom_range(0, 1)); end
               default: ;
            endcase
            gl.push_back(x);
            gen++;
         end
         if (gl.size() == 0) break;
         x = gl[0];
         halt = ($urandom_range(0, 4) == 0);
         hv[0] = ($urandom_range(0, 5) != 0);
         hv[1] = ($urandom_range(0, 3) != 0) && (gl.size() > 1);
         hs = 2'b00; hc = 2'b00; he = 2'b00;
         hs[0] = x.st; hc[0] = x.cs; he[0] = x.ex; hidx = x.idx;
         if (gl.size() > 1) begin
            hs[1] = gl[1].st; hc[1] = gl[1].cs; he[1] = gl[1].ex;
         end
         @(negedge clk);
         if (halt || !hv[0]) begin
            e = ev(2'b00, 0, 0, 0, 0);
            nvec++;
            if (obs !== e || instret !== m_instret) begin
               nerr++;
               $display("FAIL rnd_hold: out=%b exp=%b instret=%0d exp=%0d", obs, e, instret, m_instret);
            end
            adv();
         end else if (x.ex) begin
            e = ev(2'b00, 0, 0, 0, 0);
            nvec++;
            if (obs !== e || instret !== m_instret) begin
               nerr++;
               $display("FAIL rnd_ex_obs: out=%b exp=%b instret=%0d exp=%0d", obs, e, instret, m_instret);
            end
            adv();
            @(negedge clk);
            e = ev(2'b00, 0, 0, 1, 1);
            nvec++;
            if (obs !== e || instret !== m_instret || trap_idx !== x.idx) begin
               nerr++;
               $display("FAIL rnd_ex_trap: out=%b exp=%b tidx=%0d exp=%0d", obs, e, trap_idx, x.idx);
            end
            adv();
            gl.delete();
         end else if (x.st) begin
            e = ev(2'b00, 0, 0, 0, 0);
            nvec++;
            if (obs !== e || instret !== m_instret) begin
               nerr++;
               $display("FAIL rnd_st_obs: out=%b exp=%b instret=%0d exp=%0d", obs, e, instret, m_instret);
            end
            adv();
            d = $urandom_range(0, 3);
            for (int k = 0; k <= d; k++) begin
               halt = 1'($urandom_range(0, 1));
               st_ready = (k == d);
               @(negedge clk);
               e = ev((k == d) ? 2'b01 : 2'b00, 1, 0, 0, 0);
               nvec++;
               if (obs !== e || instret !== m_instret) begin
                  nerr++;
                  $display("FAIL rnd_st_wait k%0d: out=%b exp=%b instret=%0d exp=%0d", k, obs, e, instret, m_instret);
               end
               adv();
            end
            st_ready = 1'b0;
            m_instret = m_instret + 1;
            void'(gl.pop_front());
         end else if (x.cs) begin
            e = ev(2'b00, 0, 0, 0, 0);
            nvec++;
            if (obs !== e || instret !== m_instret) begin
               nerr++;
               $display("FAIL rnd_csr_obs: out=%b exp=%b instret=%0d exp=%0d", obs, e, instret, m_instret);
            end
            adv();
            d = $urandom_range(0, 3);
            tr = ($urandom_range(0, 3) == 0);
            for (int k = 0; k <= d + 1; k++) begin
               halt = 1'($urandom_range(0, 1));
               csr_done = (k == d + 1);
               csr_ex = (k == d + 1) && tr;
               @(negedge clk);
               if (k == 0) e = ev(2'b00, 0, 1, 0, 0);
               else if (k == d + 1 && !tr) e = ev(2'b01, 0, 0, 0, 0);
               else e = ev(2'b00, 0, 0, 0, 0);
               nvec++;
               if (obs !== e || instret !== m_instret) begin
                  nerr++;
                  $display("FAIL rnd_csr k%0d: out=%b exp=%b instret=%0d exp=%0d", k, obs, e, instret, m_instret);
               end
               adv();
            end
            csr_done = 1'b0;
            csr_ex = 1'b0;
            if (tr) begin
               @(negedge clk);
               e = ev(2'b00, 0, 0, 1, 1);
               nvec++;
               if (obs !== e || instret !== m_instret || trap_idx !== x.idx) begin
                  nerr++;
                  $display("FAIL rnd_csr_trap: out=%b exp=%b tidx=%0d exp=%0d", obs, e, trap_idx, x.idx);
               end
               adv();
               gl.delete();
            end else begin
               m_instret = m_instret + 1;
               void'(gl.pop_front());
            end
         end else begin
            pops = 2'b01;
            if (hv[1] && !gl[1].st && !gl[1].cs && !gl[1].ex) pops = 2'b11;
            e = ev(pops, 0, 0, 0, 0);
            nvec++;
            if (obs !== e || instret !== m_instret) begin
               nerr++;
               $display("FAIL rnd_plain: out=%b exp=%b instret=%0d exp=%0d", obs, e, instret, m_instret);
            end
            adv();
            void'(gl.pop_front());
            m_instret = m_instret + 1;
            if (pops[1]) begin
               void'(gl.pop_front());
               m_instret = m_instret + 1;
            end
         end
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid_wait;
      logic [5:0] e;
      hv = 2'b11;
      adv();
      m_instret = m_instret + 2;
      hv = 2'b01; hs = 2'b01;
      adv();
      @(negedge clk);
      e = ev(2'b00, 1, 0, 0, 0);
      nvec++;
      if (obs !== e) begin
         nerr++;
         $display("FAIL rst_wait_pre: out=%b exp=%b", obs, e);
      end
      #1 rstn = 1'b0;
      m_instret = '0;
      #1;
      e = ev(2'b00, 0, 0, 0, 0);
      nvec++;
      if (obs !== e || instret !== m_instret || trap_idx !== 5'd0) begin
         nerr++;
         $display("FAIL rst_wait_async: out=%b exp=%b instret=%0d exp=0 tidx=%0d exp=0", obs, e, instret, trap_idx);
      end
      adv();
      rstn = 1'b1;
      idle_inputs();
      st_ready = 1'b1;
      @(negedge clk);
      nvec++;
      if (obs !== e || instret !== m_instret) begin
         nerr++;
         $display("FAIL rst_wait_drop: out=%b exp=%b instret=%0d exp=%0d", obs, e, instret, m_instret);
      end
      adv();
      st_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_wrap();
      test_dual_plain();
      test_store_wait();
      test_plain_then_store();
      test_csr_trap();
      test_random();
      test_exception();
      test_halt_ignore();
      test_reset_mid_wait();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
